// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the instruction/data memory bus arbiter.
// Holds the FSM state encoding, grant identifiers and a watchdog sizing helper.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INST_BUS = 2'd1,
        DATA_BUS = 2'd2,
        RESP     = 2'd3
    } state_t;

    typedef enum logic {
        INST = 1'b0,
        DATA = 1'b1
    } grant_t;

    // Bits needed to count 0..timeout inclusive.
    function automatic int wd_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_bus_watchdog.sv
// Saturating cycle counter that flags a hung bus transaction.
// Ports: i_clk, i_rst_n, i_clr (zero count), i_en (count up), o_expired.
import mem_bus_arbiter_pkg::*;

module bus_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_limit;

    assign w_at_limit = (r_cnt == LIMIT);
    assign o_expired  = w_at_limit;

    // Stops at the limit so a stuck enable can never wrap back to zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_at_limit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-port memory bus between fetch and load/store ports.
// Ports: inst_* fetch side, data_* load/store side, mem_* bus side, timeout_err.
import mem_bus_arbiter_pkg::*;

module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_ready,
    input  logic                data_req,
    input  logic [DATA_W/8-1:0] data_wen,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_ready,
    output logic                mem_req,
    output logic [DATA_W/8-1:0] mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                timeout_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = wd_width(TIMEOUT);

    state_t            r_state;
    grant_t            r_last;
    logic              r_mem_req;
    logic [BE_W-1:0]   r_mem_wen;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_inst_rdata;
    logic [DATA_W-1:0] r_data_rdata;
    logic              r_inst_ready;
    logic              r_data_ready;
    logic              r_timeout_err;

    logic w_bus;
    logic w_wd_clr;
    logic w_wd_en;
    logic w_expired;
    logic w_pick_data;
    logic w_done;

    assign w_bus    = (r_state == INST_BUS) || (r_state == DATA_BUS);
    assign w_wd_clr = (r_state == IDLE);
    assign w_wd_en  = w_bus && !mem_ack;
    assign w_done   = mem_ack || w_expired;

    // Data wins when alone, or when both request and fetch went last.
    assign w_pick_data = data_req && (!inst_req || (r_last == INST));

    bus_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wd (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_clr     (w_wd_clr),
        .i_en      (w_wd_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_last        <= INST;
            r_mem_req     <= 1'b0;
            r_mem_wen     <= '0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_inst_rdata  <= '0;
            r_data_rdata  <= '0;
            r_inst_ready  <= 1'b0;
            r_data_ready  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_inst_ready <= 1'b0;
            r_data_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_data) begin
                        r_state     <= DATA_BUS;
                        r_last      <= DATA;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= data_addr;
                        r_mem_wen   <= data_wen;
                        r_mem_wdata <= data_wdata;
                    end else if (inst_req) begin
                        r_state     <= INST_BUS;
                        r_last      <= INST;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= inst_addr;
                        r_mem_wen   <= '0;
                        r_mem_wdata <= '0;
                    end
                end
                INST_BUS, DATA_BUS: begin
                    // An ack in the expiry cycle counts as a normal completion.
                    if (w_done) begin
                        r_mem_req <= 1'b0;
                        r_state   <= RESP;
                        if (r_state == DATA_BUS) begin
                            r_data_ready <= 1'b1;
                            r_data_rdata <= mem_ack ? mem_rdata : '0;
                        end else begin
                            r_inst_ready <= 1'b1;
                            r_inst_rdata <= mem_ack ? mem_rdata : '0;
                        end
                        if (!mem_ack) begin
                            r_timeout_err <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_wen     = r_mem_wen;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign inst_rdata  = r_inst_rdata;
    assign inst_ready  = r_inst_ready;
    assign data_rdata  = r_data_rdata;
    assign data_ready  = r_data_ready;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter (TIMEOUT=8).
// Expected responses are queued at request time and popped on each ready pulse.
module tb_mem_bus_arbiter;

    localparam int TO = 8;

    typedef struct {
        bit          port;
        logic [31:0] rd;
        bit          err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_rdata;
    logic        inst_ready;
    logic        data_req = 1'b0;
    logic [3:0]  data_wen = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic        data_ready;
    logic        mem_req;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        timeout_err;

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   err_seen = 1'b0;
    exp_t q[$];

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_rdata  (inst_rdata),
        .inst_ready  (inst_ready),
        .data_req    (data_req),
        .data_wen    (data_wen),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .data_ready  (data_ready),
        .mem_req     (mem_req),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input bit port, input logic [31:0] rd);
        exp_t e;
        e.port = port;
        e.rd   = rd;
        e.err  = err_seen;
        q.push_back(e);
    endtask

    always @(negedge clk) begin : sb_mon
        exp_t e;
        if (rst && (inst_ready || data_ready)) begin
            if (q.size() == 0) begin
                chk("spurious_rdy", {62'b0, inst_ready, data_ready}, 64'd0);
            end else begin
                e = q.pop_front();
                chk("rdy_port", {62'b0, inst_ready, data_ready},
                    e.port ? 64'd1 : 64'd2);
                chk("rdata", e.port ? data_rdata : inst_rdata, e.rd);
                chk("err", timeout_err, e.err);
                chk("req_off", mem_req, 0);
            end
        end
    end

    // One transaction; called at a negedge with the bus idle.
    task automatic txn(input bit is_data, input logic [31:0] addr,
                       input logic [3:0] wen, input logic [31:0] wd,
                       input int dly, input logic [31:0] rd, input bit to);
        int cnt;
        err_seen = err_seen | to;
        push_exp(is_data, to ? 32'h0 : rd);
        if (is_data) begin
            data_req   = 1'b1;
            data_addr  = addr;
            data_wen   = wen;
            data_wdata = wd;
        end else begin
            inst_req  = 1'b1;
            inst_addr = addr;
        end
        @(negedge clk);
        chk("mreq_lat", mem_req, 1);
        chk("maddr", mem_addr, addr);
        chk("mwen", mem_wen, is_data ? wen : 4'h0);
        chk("mwdata", mem_wdata, is_data ? wd : 32'h0);
        cnt = 0;
        if (!to) begin
            repeat (dly - 1) @(negedge clk);
            chk("mreq_held", mem_req, 1);
            mem_ack   = 1'b1;
            mem_rdata = rd;
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            chk("rdy_lat", is_data ? data_ready : inst_ready, 1);
        end else begin
            while (!(is_data ? data_ready : inst_ready) && cnt < 40) begin
                @(negedge clk);
                cnt++;
            end
            chk("to_lat", cnt, TO + 1);
        end
        inst_req = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        chk("rdy_pulse", {62'b0, inst_ready, data_ready}, 64'd0);
        chk("rdata_hold", is_data ? data_rdata : inst_rdata,
            to ? 32'h0 : rd);
        chk("err_sticky", timeout_err, err_seen);
    endtask

    initial begin : main
        logic [31:0] rdv [3];
        int cnt;
        rdv[0] = 32'hD0D0_0000;
        rdv[1] = 32'h1111_0001;
        rdv[2] = 32'hD0D0_0002;

        repeat (2) @(negedge clk);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_rdy", {62'b0, inst_ready, data_ready}, 64'd0);
        chk("rst_err", timeout_err, 0);
        rst = 1'b1;
        @(negedge clk);

        // Both ports held from reset: DATA, INST, DATA.
        for (int i = 0; i < 3; i++) begin
            push_exp(i % 2 == 0, rdv[i]);
        end
        inst_addr  = 32'h0000_1000;
        data_addr  = 32'h0000_2000;
        data_wen   = 4'h0;
        data_wdata = 32'h0;
        inst_req   = 1'b1;
        data_req   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cnt = 0;
            while (!mem_req && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
            chk("alt_wait", cnt < 20, 1);
            chk("alt_grant", mem_addr,
                (i % 2 == 0) ? 32'h2000 : 32'h1000);
            mem_ack   = 1'b1;
            mem_rdata = rdv[i];
            @(negedge clk);
            mem_ack = 1'b0;
            chk("alt_rdy", {62'b0, inst_ready, data_ready},
                (i % 2 == 0) ? 64'd1 : 64'd2);
            if (i == 2) begin
                inst_req = 1'b0;
                data_req = 1'b0;
            end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);

        txn(1'b0, 32'hBFC0_0000, 4'h0, 32'h0, 3, 32'h2408_0001, 1'b0);
        txn(1'b1, 32'h0000_0102, 4'b0010, 32'h0000_AB00, 1,
            32'h5555_AAAA, 1'b0);

        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("spur_req", mem_req, 0);

        // Ack lands exactly in the expiry cycle.
        txn(1'b1, 32'h0000_0200, 4'h0, 32'h0, TO + 1, 32'hC0FF_EE01, 1'b0);
        txn(1'b1, 32'h0000_0300, 4'h0, 32'h0, 0, 32'h0, 1'b1);
        txn(1'b0, 32'h0000_0400, 4'h0, 32'h0, 2, 32'h0BAD_F00D, 1'b0);

        // Reset while the fetch is on the bus.
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0500;
        @(negedge clk);
        chk("mid_req", mem_req, 1);
        rst = 1'b0;
        #1;
        chk("mid_mreq", mem_req, 0);
        chk("mid_maddr", mem_addr, 0);
        chk("mid_wen", mem_wen, 0);
        chk("mid_wdata", mem_wdata, 0);
        chk("mid_irdata", inst_rdata, 0);
        chk("mid_drdata", data_rdata, 0);
        chk("mid_err", timeout_err, 0);
        inst_req = 1'b0;
        err_seen = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_7777;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("late_ack", {62'b0, inst_ready, data_ready}, 64'd0);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : guard
        #200000;
        $display("FAIL global_timeout: got hang want finish");
        $fatal(1);
    end

endmodule
